// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction-fetch stage:
//   - fetch_state_e : FSM encoding for REQUEST / WAIT / HOLD
//   - INSTSIZE_DEF  : default instruction width
//   - PC_INC        : sequential PC increment (one 32-bit instruction)
//   - ALIGN_BITS    : number of low PC bits forced to zero on redirect
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_REQUEST = 2'd0,
        ST_WAIT    = 2'd1,
        ST_HOLD    = 2'd2
    } fetch_state_e;

    localparam int unsigned INSTSIZE_DEF = 32;
    localparam int unsigned PC_INC       = 4;
    localparam int unsigned ALIGN_BITS   = 2;

endpackage

// File: rtl/fetch_pc.sv
// -----------------------------------------------------------------------------
// fetch_pc
// Program-counter register with its next-pc selection.
// Priority: reset > branch (word-aligned target) > advance (pc + 4) > hold.
// pc + 4 wraps modulo 2^WORDSIZE with no overflow indication.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous active-high reset, loads RESETPC
//   branch       in   redirect request
//   branchtarget in   redirect address; low two bits are cleared
//   advance      in   step to the next sequential instruction
//   pc           out  current program counter
// -----------------------------------------------------------------------------
module fetch_pc
    import fetch_unit_pkg::*;
#(
    parameter int unsigned             WORDSIZE = 64,
    parameter logic [WORDSIZE-1:0]     RESETPC  = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                branch,
    input  logic [WORDSIZE-1:0] branchtarget,
    input  logic                advance,
    output logic [WORDSIZE-1:0] pc
);

    // Clears the byte-offset bits of a redirect target.
    localparam logic [WORDSIZE-1:0] ALIGN_MASK = {{(WORDSIZE-ALIGN_BITS){1'b1}}, {ALIGN_BITS{1'b0}}};

    logic [WORDSIZE-1:0] pc_r;
    logic [WORDSIZE-1:0] pc_nxt_s;

    // Next-pc mux; a redirect always overrides sequential advance.
    always_comb begin
        pc_nxt_s = pc_r;
        if (branch) begin
            pc_nxt_s = branchtarget & ALIGN_MASK;
        end else if (advance) begin
            pc_nxt_s = pc_r + WORDSIZE'(PC_INC);
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // PC register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= RESETPC;
        end else begin
            pc_r <= pc_nxt_s;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage. Holds the PC, issues one outstanding request at a
// time to instruction memory (req/gnt/valid), and presents the fetched
// instruction plus its PC to decode (valid/ready). A branch redirect replaces
// the PC and squashes any in-flight or held wrong-path instruction.
//
// Optional build macro: FETCH_COUNT_EN adds fetchcount / squashcount outputs.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous active-high reset
//   branch       in   redirect request from branch control
//   branchtarget in   redirect address (bits [1:0] ignored)
//   imemreq      out  request valid to instruction memory
//   imemaddr     out  request address (== pc)
//   imemgnt      in   memory accepts the request this cycle
//   imemvalid    in   response valid
//   imemdata     in   response instruction
//   instvalid    out  instruction available to decode
//   instready    in   decode accepts this cycle
//   inst         out  held instruction
//   instpc       out  address of inst
//   fetchcount   out  (FETCH_COUNT_EN) instructions accepted by decode
//   squashcount  out  (FETCH_COUNT_EN) responses discarded / held insts dropped
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned         WORDSIZE = 64,
    parameter int unsigned         INSTSIZE = INSTSIZE_DEF,
    parameter logic [WORDSIZE-1:0] RESETPC  = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                branch,
    input  logic [WORDSIZE-1:0] branchtarget,
    output logic                imemreq,
    output logic [WORDSIZE-1:0] imemaddr,
    input  logic                imemgnt,
    input  logic                imemvalid,
    input  logic [INSTSIZE-1:0] imemdata,
    output logic                instvalid,
    input  logic                instready,
    output logic [INSTSIZE-1:0] inst,
    output logic [WORDSIZE-1:0] instpc
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0]         fetchcount,
    output logic [31:0]         squashcount
`endif
);

    fetch_state_e        state_r;
    fetch_state_e        state_nxt_s;
    logic                squash_r;
    logic                squash_nxt_s;
    logic                imemreq_r;
    logic                instvalid_r;
    logic [INSTSIZE-1:0] inst_r;
    logic [WORDSIZE-1:0] instpc_r;
    logic                capture_s;
    logic                advance_s;
    logic                granted_s;
    logic [WORDSIZE-1:0] pc_s;

    fetch_pc #(
        .WORDSIZE (WORDSIZE),
        .RESETPC  (RESETPC)
    ) u_fetch_pc (
        .clk          (clk),
        .reset        (reset),
        .branch       (branch),
        .branchtarget (branchtarget),
        .advance      (advance_s),
        .pc           (pc_s)
    );

    // A grant only counts while our registered request is actually driven.
    assign granted_s = imemreq_r & imemgnt;

    // Next-state, squash and capture decisions for the fetch FSM.
    always_comb begin
        state_nxt_s  = state_r;
        squash_nxt_s = squash_r;
        capture_s    = 1'b0;
        advance_s    = 1'b0;
        case (state_r)
            ST_REQUEST: begin
                if (granted_s) begin
                    // Redirect in the grant cycle: the old-pc request is now
                    // in flight and its response must be thrown away.
                    state_nxt_s  = ST_WAIT;
                    squash_nxt_s = branch;
                end else begin
                    state_nxt_s  = ST_REQUEST;
                    squash_nxt_s = squash_r;
                end
            end
            ST_WAIT: begin
                if (imemvalid) begin
                    if (squash_r || branch) begin
                        // Wrong-path response: drop it and refetch from pc.
                        state_nxt_s  = ST_REQUEST;
                        squash_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s  = ST_HOLD;
                        squash_nxt_s = 1'b0;
                        capture_s    = 1'b1;
                        advance_s    = 1'b1;
                    end
                end else if (branch) begin
                    state_nxt_s  = ST_WAIT;
                    squash_nxt_s = 1'b1;
                end else begin
                    state_nxt_s  = ST_WAIT;
                    squash_nxt_s = squash_r;
                end
            end
            ST_HOLD: begin
                // A branch drops the held instruction (unless decode takes it
                // in the same cycle); either way pc already follows the target.
                if (instready || branch) begin
                    state_nxt_s = ST_REQUEST;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
                squash_nxt_s = 1'b0;
            end
            default: begin
                state_nxt_s  = ST_REQUEST;
                squash_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM state, squash flag and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_REQUEST;
            squash_r    <= 1'b0;
            imemreq_r   <= 1'b0;
            instvalid_r <= 1'b0;
            inst_r      <= '0;
            instpc_r    <= '0;
        end else begin
            state_r     <= state_nxt_s;
            squash_r    <= squash_nxt_s;
            // Outputs follow the state being entered so they line up with it.
            imemreq_r   <= (state_nxt_s == ST_REQUEST);
            instvalid_r <= (state_nxt_s == ST_HOLD);
            if (capture_s) begin
                inst_r   <= imemdata;
                instpc_r <= pc_s;
            end else begin
                inst_r   <= inst_r;
                instpc_r <= instpc_r;
            end
        end
    end

    assign imemreq   = imemreq_r;
    assign imemaddr  = pc_s;
    assign instvalid = instvalid_r;
    assign inst      = inst_r;
    assign instpc    = instpc_r;

`ifdef FETCH_COUNT_EN
    logic [31:0] fetchcount_r;
    logic [31:0] squashcount_r;
    logic        fetch_evt_s;
    logic        squash_evt_s;

    assign fetch_evt_s  = instvalid_r & instready;
    // Discarded response in WAIT, or held instruction dropped by a branch.
    assign squash_evt_s = ((state_r == ST_WAIT) & imemvalid & (squash_r | branch)) |
                          ((state_r == ST_HOLD) & branch & ~instready);

    // Wrapping event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetchcount_r  <= 32'd0;
            squashcount_r <= 32'd0;
        end else begin
            if (fetch_evt_s) begin
                fetchcount_r <= fetchcount_r + 32'd1;
            end else begin
                fetchcount_r <= fetchcount_r;
            end
            if (squash_evt_s) begin
                squashcount_r <= squashcount_r + 32'd1;
            end else begin
                squashcount_r <= squashcount_r;
            end
        end
    end

    assign fetchcount  = fetchcount_r;
    assign squashcount = squashcount_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int W = 64;
    localparam int I = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         branch = 1'b0;
    logic [W-1:0] branchtarget = '0;
    logic         imemreq;
    logic [W-1:0] imemaddr;
    logic         imemgnt = 1'b0;
    logic         imemvalid = 1'b0;
    logic [I-1:0] imemdata = '0;
    logic         instvalid;
    logic         instready = 1'b1;
    logic [I-1:0] inst;
    logic [W-1:0] instpc;
`ifdef FETCH_COUNT_EN
    logic [31:0]  fetchcount;
    logic [31:0]  squashcount;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // memory model knobs and state
    int           gnt_delay = 0;
    int           latency = 1;
    int           req_wait = 0;
    int           lat_cnt = 0;
    bit           pend = 1'b0;
    logic [W-1:0] pend_addr = '0;
    logic [W-1:0] grant_q[$];

    always #5 clk = ~clk;

    fetch_unit dut (
`ifdef FETCH_COUNT_EN
        .fetchcount   (fetchcount),
        .squashcount  (squashcount),
`endif
        .clk          (clk),
        .reset        (reset),
        .branch       (branch),
        .branchtarget (branchtarget),
        .imemreq      (imemreq),
        .imemaddr     (imemaddr),
        .imemgnt      (imemgnt),
        .imemvalid    (imemvalid),
        .imemdata     (imemdata),
        .instvalid    (instvalid),
        .instready    (instready),
        .inst         (inst),
        .instpc       (instpc)
    );

    function automatic logic [I-1:0] mem_word(input logic [W-1:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hCAFE_0000;
    endfunction

    function automatic logic [W-1:0] q_at(input int idx);
        if (idx < grant_q.size()) return grant_q[idx];
        return 64'hDEAD_BEEF_DEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        branch = 1'b0;
        tick();
        tick();
        grant_q.delete();
        reset = 1'b0;
    endtask

    task automatic wait_inst(input string tag, input logic [W-1:0] exp_pc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (instvalid) seen = 1'b1;
        end
        check({tag, "_seen"}, W'(seen), 64'd1);
        check({tag, "_pc"}, instpc, exp_pc);
        check({tag, "_inst"}, W'(inst), W'(mem_word(exp_pc)));
    endtask

    // instruction memory: one grant after gnt_delay waiting cycles, response latency cycles later
    initial begin
        forever begin
            @(negedge clk);
            imemgnt   = 1'b0;
            imemvalid = 1'b0;
            if (reset) begin
                pend     = 1'b0;
                req_wait = 0;
            end else if (pend) begin
                if (lat_cnt <= 1) begin
                    imemvalid = 1'b1;
                    imemdata  = mem_word(pend_addr);
                    pend      = 1'b0;
                end else begin
                    lat_cnt--;
                end
            end else if (imemreq) begin
                if (req_wait >= gnt_delay) begin
                    imemgnt   = 1'b1;
                    pend      = 1'b1;
                    lat_cnt   = latency;
                    pend_addr = imemaddr;
                    grant_q.push_back(imemaddr);
                    req_wait  = 0;
                end else begin
                    req_wait++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // S1: reset values, sequential fetch, 3-cycle latency to first instvalid
        gnt_delay = 0; latency = 1; instready = 1'b1;
        do_reset();
        check("rst_imemreq", W'(imemreq), 64'd0);
        check("rst_instvalid", W'(instvalid), 64'd0);
        check("rst_inst", W'(inst), 64'd0);
        check("rst_instpc", instpc, 64'd0);
        tick();
        check("s1_req_t1", W'(imemreq), 64'd1);
        check("s1_addr_t1", imemaddr, 64'h0);
        check("s1_iv_t1", W'(instvalid), 64'd0);
        tick();
        check("s1_iv_t2", W'(instvalid), 64'd0);
        tick();
        check("s1_iv_t3", W'(instvalid), 64'd1);
        check("s1_pc0", instpc, 64'h0);
        check("s1_inst0", W'(inst), W'(mem_word(64'h0)));
        wait_inst("s1_i4", 64'h4);
        wait_inst("s1_i8", 64'h8);
        check("s1_g0", q_at(0), 64'h0);
        check("s1_g1", q_at(1), 64'h4);
        check("s1_g2", q_at(2), 64'h8);

        // S2: grant delayed 4 cycles
        gnt_delay = 4;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("s2_req_%0d", i), W'(imemreq), 64'd1);
            check($sformatf("s2_addr_%0d", i), imemaddr, 64'h0);
            check($sformatf("s2_iv_%0d", i), W'(instvalid), 64'd0);
        end
        tick();
        check("s2_iv_6", W'(instvalid), 64'd0);
        tick();
        check("s2_iv_7", W'(instvalid), 64'd1);
        check("s2_pc", instpc, 64'h0);
        gnt_delay = 0;

        // S3: decode stalls 5 cycles in HOLD
        instready = 1'b0;
        do_reset();
        tick(); tick(); tick();
        check("s3_iv", W'(instvalid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("s3_iv_%0d", i), W'(instvalid), 64'd1);
            check($sformatf("s3_pc_%0d", i), instpc, 64'h0);
            check($sformatf("s3_inst_%0d", i), W'(inst), W'(mem_word(64'h0)));
            check($sformatf("s3_req_%0d", i), W'(imemreq), 64'd0);
        end
        instready = 1'b1;
        tick();
        check("s3_iv_after", W'(instvalid), 64'd0);
        check("s3_req_after", W'(imemreq), 64'd1);
        check("s3_addr_after", imemaddr, 64'h4);

        // S4: branch while in WAIT
        latency = 3;
        do_reset();
        tick(); tick();
        check("s4_wait_req", W'(imemreq), 64'd0);
        branch = 1'b1; branchtarget = 64'h103;
        tick();
        branch = 1'b0;
        check("s4_wait_req2", W'(imemreq), 64'd0);
        wait_inst("s4_tgt", 64'h100);
        check("s4_nq", W'(grant_q.size()), 64'd2);
        check("s4_g1", q_at(1), 64'h100);
`ifdef FETCH_COUNT_EN
        check("s4_fcnt", W'(fetchcount), 64'd0);
        check("s4_scnt", W'(squashcount), 64'd1);
`endif

        // S5: branch in the same cycle as the grant
        latency = 2;
        do_reset();
        tick();
        check("s5_req", W'(imemreq), 64'd1);
        branch = 1'b1; branchtarget = 64'h200;
        tick();
        branch = 1'b0;
        check("s5_req_wait", W'(imemreq), 64'd0);
        check("s5_addr", imemaddr, 64'h200);
        wait_inst("s5_tgt", 64'h200);
        check("s5_g0", q_at(0), 64'h0);
        check("s5_g1", q_at(1), 64'h200);
`ifdef FETCH_COUNT_EN
        check("s5_scnt", W'(squashcount), 64'd1);
`endif

        // S6: redirect in REQUEST before grant, then pc wrap
        latency = 1; gnt_delay = 2;
        do_reset();
        tick();
        branch = 1'b1; branchtarget = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        branch = 1'b0;
        check("s6_req", W'(imemreq), 64'd1);
        check("s6_addr", imemaddr, 64'hFFFF_FFFF_FFFF_FFFC);
        wait_inst("s6_top", 64'hFFFF_FFFF_FFFF_FFFC);
        wait_inst("s6_wrap", 64'h0);
        check("s6_g0", q_at(0), 64'hFFFF_FFFF_FFFF_FFFC);
        check("s6_g1", q_at(1), 64'h0);
        gnt_delay = 0;

        // S7: branch in HOLD, with and without simultaneous instready
        instready = 1'b0;
        do_reset();
        tick(); tick(); tick();
        check("s7_iv", W'(instvalid), 64'd1);
        branch = 1'b1; branchtarget = 64'h300;
        tick();
        branch = 1'b0;
        check("s7_drop_iv", W'(instvalid), 64'd0);
        check("s7_drop_req", W'(imemreq), 64'd1);
        check("s7_drop_addr", imemaddr, 64'h300);
        wait_inst("s7_tgt", 64'h300);
        instready = 1'b1; branch = 1'b1; branchtarget = 64'h400;
        tick();
        branch = 1'b0;
        check("s7_both_iv", W'(instvalid), 64'd0);
        check("s7_both_addr", imemaddr, 64'h400);
`ifdef FETCH_COUNT_EN
        check("s7_fcnt", W'(fetchcount), 64'd1);
        check("s7_scnt", W'(squashcount), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of branch control and decode.
- Holds the PC and issues one outstanding request at a time to instruction memory over a req/gnt/valid handshake.
- Presents the fetched instruction and its PC to decode over a valid/ready handshake.
- Redirects the PC when the `branch` output of branch control asserts with a target computed by the datapath, and squashes any in-flight or held wrong-path fetch.

Parameters:
- WORDSIZE, 64, PC/address width.
- INSTSIZE, 32, instruction width.
- RESETPC, 0, PC loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- branch  input  1  redirect request from branch control, sampled every cycle.
- branchtarget  input  WORDSIZE  redirect address; bits [1:0] ignored and forced to zero.
- imemreq  output  1  request valid to instruction memory.
- imemaddr  output  WORDSIZE  request address, equal to pc.
- imemgnt  input  1  memory accepts the request this cycle (imemreq & imemgnt).
- imemvalid  input  1  response data valid; at most one per accepted request, at least 1 cycle after grant.
- imemdata  input  INSTSIZE  response instruction.
- instvalid  output  1  instruction available to decode.
- instready  input  1  decode accepts this cycle.
- inst  output  INSTSIZE  held instruction.
- instpc  output  WORDSIZE  address of inst.

Behaviour:
- Reset (synchronous, active-high):
  - pc=RESETPC, state=REQUEST, squash=0.
  - instvalid=0, inst=0, instpc=0, imemreq=0 in the reset cycle.
  - Reset mid-transaction abandons everything; a late imemvalid arriving after reset is ignored until a new grant.
- FSM states: REQUEST, WAIT, HOLD.
- REQUEST:
  - imemreq=1, imemaddr=pc.
  - On imemgnt, go to WAIT.
  - imemaddr is stable until granted, unless redirected.
- WAIT:
  - imemreq=0.
  - On imemvalid with squash=0: inst<=imemdata, instpc<=pc, pc<=pc+4, instvalid<=1, go to HOLD.
  - On imemvalid with squash=1: discard data, squash<=0, go to REQUEST.
- HOLD:
  - instvalid=1; inst and instpc stable.
  - On instready: instvalid<=0, go to REQUEST.
- Latency: grant at cycle t, imemvalid at t+k gives instvalid at t+k+1. Minimum 3 cycles per instruction; no overlap required.
- PC arithmetic: pc+4 wraps modulo 2^WORDSIZE without a flag.
- Redirect (branch=1) has priority over all other updates of pc:
  - pc<=branchtarget & ~3 in every state.
  - REQUEST, no grant this cycle: stay in REQUEST; imemaddr shows the target next cycle.
  - REQUEST, grant this cycle: go to WAIT with squash<=1 (old-pc request in flight).
  - WAIT: squash<=1. If imemvalid arrives in the same cycle, discard it, squash<=0, go to REQUEST.
  - HOLD: instvalid<=0 next cycle and go to REQUEST. A simultaneous instready is accepted by decode, but pc still takes the target, not pc+4.
  - Consecutive branch cycles: the last target wins.
- instvalid never drops without instready, except on branch or reset.

Optional Feature:
- FETCH_COUNT_EN defined:
  - Adds outputs fetchcount[31:0] and squashcount[31:0], both reset to 0 and wrapping.
  - fetchcount increments on instvalid&instready.
  - squashcount increments each time a response is discarded or a held instruction is dropped by branch.
- Undefined: ports absent, no counter logic.

Decomposition:
- Shared header (alongside bus.vh): state encoding for REQUEST/WAIT/HOLD, INSTSIZE, PC increment constant 4.
- One natural sub-module, fetch_pc: the pc register with next-pc mux (reset / branch target aligned / pc+4 / hold).
- The FSM, squash flag, and output register stay in fetch_unit.

Test Plan:
- Reset with RESETPC=0, memory latency 1, instready=1 → requests at 0x0, 0x4, 0x8 in order; instpc sequence 0x0, 0x4, 0x8; instvalid first high 3 cycles after reset release.
- Grant delayed 4 cycles → imemaddr stays 0x0 with imemreq=1 throughout; no instvalid until after the grant and response.
- instready held low 5 cycles in HOLD → inst/instpc stable; no new imemreq; then one instready moves the FSM to REQUEST at pc+4.
- branch=1, branchtarget=0x103 while in WAIT → response for the old pc dropped; next request at 0x100; first delivered instpc=0x100.
- branch in the same cycle as imemgnt → squash set; the following imemvalid is discarded; the next request is to the target.
- Wrap: pc=0xFFFF_FFFF_FFFF_FFFC delivered → next request 0x0. With FETCH_COUNT_EN, fetchcount and squashcount match the scenario counts.
